hammer_mc_s: RTL
================

Name: hammer_mc_s

Overview:
Parametrised multi-channel Hamming(7,4) serial link with built-in error injection and single-error correction.
- Accepts one NCH×4-bit word through a valid/ready handshake.
- Splits the word into 4-bit lanes, Hamming-encodes each lane and shifts each codeword over a 1-bit internal line.
- Optionally flips one programmable bit per lane on that line.
- Deserialises, corrects and returns the word with per-lane error flags and saturating corrected-error counters.
- Next-generation replacement for the fixed 4-lane router/inject/correct chain; also acts as a self-checking link test block.

Parameters:
- NCH, 4, number of lanes; NCH ≥ 1.
- CNT_W, 8, width of each per-lane corrected-error counter.

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst, input, 1, synchronous active-low reset.
- in_data, input, NCH*4, lane k = in_data[4k+3:4k].
- in_valid, input, 1, word offered.
- in_ready, output, 1, block idle and able to accept.
- err_pos, input, NCH*3, lane k = err_pos[3k+2:3k]. 0 = no injection; 1..7 = flip that codeword position.
- out_data, output, NCH*4, corrected word; holds its value between updates.
- out_valid, output, 1, one-cycle pulse when out_data/out_err are updated.
- out_err, output, NCH, lane k syndrome was nonzero and the lane was corrected.
- err_cnt, output, NCH*CNT_W, lane k count of corrected words; saturating.

Behaviour:
- Reset: rst sampled low at an edge gives state IDLE, bit_cnt=0, out_data=0, out_valid=0, out_err=0, err_cnt=0 and all shift registers 0.
- Reset has priority over every other event. A reset during SHIFT or CHECK aborts the word; no out_valid follows.
- Codeword layout, positions 1..7 = p1 p2 d0 p4 d1 d2 d3, where:
  - p1 = d0^d1^d3
  - p2 = d0^d2^d3
  - p4 = d1^d2^d3
  - d0 is the lane LSB.
- Serial order is position 1 first.
- FSM, IDLE → SHIFT → CHECK → IDLE:
  - IDLE: in_ready=1, combinational from state. An edge with in_valid=1 loads every lane's codeword and latches err_pos, then moves to SHIFT with bit_cnt=0. in_data/err_pos changes after acceptance have no effect.
  - SHIFT: in_ready=0. Each edge, every lane drives codeword position bit_cnt+1. The received bit = driven bit XOR (latched err_pos == bit_cnt+1), shifted into the lane receive register. After the bit_cnt==6 edge, move to CHECK.
  - CHECK: in_ready=0. Syndrome s = {s4,s2,s1} is computed from the received codeword. If s≠0, flip position s. Extract d3..d0.
  - CHECK edge: registers out_data and out_err, sets out_valid=1, increments err_cnt[k] where out_err[k] is set (holds at 2^CNT_W−1), and returns to IDLE.
- out_valid clears on the following edge.
- Timing: accept at edge E0, out_valid high after E8, next accept possible at E9. Throughput is 1 word per 9 cycles.
- err_pos values 1..7 are always corrected exactly. The lane counter counts only when s≠0.
- in_valid while not IDLE is ignored; there is no queuing. The source must hold in_valid until in_ready.

Decomposition:
- Shared package hammer_pkg:
  - CW_LEN=7, POS_W=3
  - state encoding IDLE/SHIFT/CHECK
  - encode function (4→7) and syndrome function (7→3)
- Sub-module hamming_lane_s, generated NCH times. It contains the lane transmit shift register, injection XOR, receive register, correction, out_err bit and saturating counter.
- Top level holds the FSM, bit_cnt, in_ready and out_valid, and broadcasts load/shift/check strobes to the lanes.

Test Plan:
- Reset then NCH=4, in_data=16'hA5C3, err_pos=0 → out_valid exactly 8 edges after acceptance; out_data=16'hA5C3; out_err=4'b0000; err_cnt all 0.
- Lane 0 nibble 4'h3, err_pos lane0=5 → line carries 0,1,1,1,0,0,0; syndrome 5; out_data lane0=4'h3; out_err=4'b0001; err_cnt[0]=1.
- in_data=16'hFFFF, err_pos={3'd7,3'd1,3'd3,3'd4} → out_data=16'hFFFF; out_err=4'b1111; each err_cnt=1.
- Two back-to-back words with in_valid held high → second acceptance at E9. in_valid toggling during SHIFT is ignored. Exactly two out_valid pulses.
- rst low at the 4th SHIFT edge → in_ready=1 next cycle; no out_valid; out_data=0. A new word then completes normally.
- CNT_W=2, lane 2 injected on 5 consecutive words → err_cnt[2] sequence 1,2,3,3,3; data always correct.

Source files
------------

// File: rtl/hammer_pkg.sv
// Shared definitions for the multi-channel Hamming(7,4) serial link.
// Holds the codeword geometry, the controller state type and the
// encode/syndrome helpers used by every lane.
// Codeword vectors are stored with bit i-1 holding codeword position i,
// so bit 0 is position 1 (p1), the first bit on the line.
package hammer_pkg;

    localparam int unsigned CW_LEN = 7;
    localparam int unsigned POS_W  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCheck
    } state_e;

    // Positions 1..7 = p1 p2 d0 p4 d1 d2 d3
    function automatic logic [CW_LEN-1:0] encode(input logic [3:0] d);
        logic [CW_LEN-1:0] cw;
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[2] = d[0];
        cw[3] = d[1] ^ d[2] ^ d[3];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        return cw;
    endfunction

    // Returns {s4, s2, s1}; a nonzero value names the flipped position
    function automatic logic [POS_W-1:0] syndrome(input logic [CW_LEN-1:0] cw);
        logic s1, s2, s4;
        s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/hamming_lane_s.sv
// One lane of the Hamming(7,4) serial link.
// Encodes a nibble on load, shifts the codeword out one bit per shift
// strobe through an optional single-bit error injector into a receive
// register, then corrects/decodes on the check strobe and maintains a
// saturating count of corrected words.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   load         capture in_nib codeword and err_pos
//   shift        move one codeword bit across the line
//   check        correct received codeword, update outputs and counter
//   bit_cnt      index of the bit being shifted (position bit_cnt+1)
//   in_nib       lane data nibble (d3..d0)
//   err_pos      position to flip on the line, 0 = none
//   out_nib      corrected nibble, held between checks
//   out_err      last checked word had a nonzero syndrome
//   err_cnt      saturating count of corrected words
module hamming_lane_s
    import hammer_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             check,
    input  logic [POS_W-1:0] bit_cnt,
    input  logic [3:0]       in_nib,
    input  logic [POS_W-1:0] err_pos,
    output logic [3:0]       out_nib,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CW_LEN-1:0] tx_q;
    logic [CW_LEN-1:0] rx_q;
    logic [POS_W-1:0]  pos_q;
    logic [3:0]        out_nib_q;
    logic              out_err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              line_bit;
    logic [POS_W-1:0]  syn;
    logic [CW_LEN-1:0] fixed;

    // bit_cnt+1 is never 0, so err_pos == 0 never injects
    assign line_bit = tx_q[0] ^ (pos_q == (bit_cnt + 3'd1));

    always_comb begin
        syn   = syndrome(rx_q);
        fixed = rx_q;
        for (int i = 0; i < CW_LEN; i++) begin
            if (syn == POS_W'(i + 1)) begin
                fixed[i] = ~rx_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_q      <= '0;
            rx_q      <= '0;
            pos_q     <= '0;
            out_nib_q <= '0;
            out_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (load) begin
                tx_q  <= encode(in_nib);
                pos_q <= err_pos;
            end else if (shift) begin
                // Transmit LSB first; receive fills from the top so that
                // after seven shifts position 1 lands in bit 0
                tx_q <= {1'b0, tx_q[CW_LEN-1:1]};
                rx_q <= {line_bit, rx_q[CW_LEN-1:1]};
            end
            if (check) begin
                out_nib_q <= {fixed[6], fixed[5], fixed[4], fixed[2]};
                out_err_q <= (syn != '0);
                if ((syn != '0) && (cnt_q != CntMax)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign out_nib = out_nib_q;
    assign out_err = out_err_q;
    assign err_cnt = cnt_q;

endmodule

// File: rtl/hammer_mc_s.sv
// Multi-channel Hamming(7,4) serial link with error injection and
// single-error correction. Accepts an NCH x 4-bit word, sends each lane
// over its own 1-bit line (7 cycles), corrects and returns the word with
// per-lane error flags and saturating error counters. 1 word / 9 cycles.
// Ports:
//   clk, rst    clock, synchronous active-low reset
//   in_data     NCH nibbles, lane k = in_data[4k+3:4k]
//   in_valid    word offered; must be held until in_ready
//   in_ready    controller idle and able to accept
//   err_pos     NCH 3-bit injection positions, 0 = none
//   out_data    corrected word, held between updates
//   out_valid   one-cycle pulse when out_data/out_err update
//   out_err     per-lane corrected flag
//   err_cnt     per-lane saturating corrected-word counters
module hammer_mc_s
    import hammer_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*4-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*3-1:0]     err_pos,
    output logic [NCH*4-1:0]     out_data,
    output logic                 out_valid,
    output logic [NCH-1:0]       out_err,
    output logic [NCH*CNT_W-1:0] err_cnt
);

    localparam logic [POS_W-1:0] LastBit = POS_W'(CW_LEN - 1);

    state_e           state_q, state_d;
    logic [POS_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             out_valid_q;
    logic             load, shift, check;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        in_ready  = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        check     = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_d   = StShift;
                    bit_cnt_d = '0;
                end
            end
            StShift: begin
                shift = 1'b1;
                if (bit_cnt_q == LastBit) begin
                    state_d   = StCheck;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StCheck: begin
                check   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            out_valid_q <= check;
        end
    end

    assign out_valid = out_valid_q;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        hamming_lane_s #(
            .CNT_W(CNT_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (load),
            .shift   (shift),
            .check   (check),
            .bit_cnt (bit_cnt_q),
            .in_nib  (in_data[4*k +: 4]),
            .err_pos (err_pos[3*k +: 3]),
            .out_nib (out_data[4*k +: 4]),
            .out_err (out_err[k]),
            .err_cnt (err_cnt[CNT_W*k +: CNT_W])
        );
    end

endmodule
